// File: rtl/freq_meter_pkg.sv
// Shared types and default sizing for the square-wave frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_e;

    localparam int DEF_CNT_W   = 31;
    localparam int DEF_TIMEOUT = 100_000_000;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer plus edge-detect register; emits registered one-clock
// rise/fall strobes three clocks after an input transition. Reusable for switches.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    // [0],[1] synchronize; [2] holds the previous synchronized level
    logic [2:0] sync_q;
    logic       rise_q;
    logic       fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
            rise_q <= sync_q[1] & ~sync_q[2];
            fall_q <= ~sync_q[1] & sync_q[2];
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow square wave in system clocks.
// Define FREQ_METER_DUTY_EN to build high-time tracking; otherwise high_time is 0.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             no_signal
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic rise;
    logic fall;

    sync_edge u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             no_sig_q, no_sig_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        no_sig_d = no_sig_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = ONE_C;
                end
            end
            MEAS: begin
                // A rise coinciding with the timeout count still completes a measurement
                if (rise) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    no_sig_d = 1'b0;
                    cnt_d    = ONE_C;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d  = IDLE;
                    no_sig_d = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            no_sig_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            no_sig_q <= no_sig_d;
        end
    end

`ifdef FREQ_METER_DUTY_EN
    logic [CNT_W-1:0] fall_cap_q, fall_cap_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             fell_q, fell_d;

    always_comb begin
        fall_cap_d = fall_cap_q;
        high_d     = high_q;
        fell_d     = fell_q;
        if (state_q == MEAS && fall) begin
            fall_cap_d = cnt_q;
            fell_d     = 1'b1;
        end
        if (rise) begin
            // No fall seen since the last rise means the input stayed high all cycle
            if (state_q == MEAS) begin
                high_d = fell_q ? fall_cap_q : cnt_q;
            end
            fell_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_cap_q <= '0;
            high_q     <= '0;
            fell_q     <= 1'b0;
        end else begin
            fall_cap_q <= fall_cap_d;
            high_q     <= high_d;
            fell_q     <= fell_d;
        end
    end

    assign high_time = high_q;
`else
    logic unused_fall;
    assign unused_fall = fall;
    assign high_time   = '0;
`endif

    assign period    = period_q;
    assign valid     = valid_q;
    assign no_signal = no_sig_q;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: expected results are queued when each rise is
// driven and compared (value and arrival cycle) when valid strobes.
module tb_freq_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             no_signal;

    freq_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .no_signal (no_signal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int p;
        int h;
        int at;
    } exp_t;
    exp_t sb[$];

    bit armed = 1'b0;
    bit fell = 1'b0;
    int last_rise_c = 0;
    int last_fall_c = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_rise();
        exp_t e;
        sig_in = 1'b1;
        if (armed) begin
            e.p = cyc - last_rise_c;
`ifdef FREQ_METER_DUTY_EN
            e.h = fell ? (last_fall_c - last_rise_c) : e.p;
`else
            e.h = 0;
`endif
            e.at = cyc + 4;
            sb.push_back(e);
        end
        armed = 1'b1;
        fell = 1'b0;
        last_rise_c = cyc;
    endtask

    task automatic do_fall();
        sig_in = 1'b0;
        if (armed) begin
            fell = 1'b1;
            last_fall_c = cyc;
        end
    endtask

    task automatic run_cycle(input int p, input int h);
        do_rise();
        tick(h);
        do_fall();
        tick(p - h);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid: valid=1 at cycle %0d period=%0d, required no valid", cyc, period);
            end else begin
                e = sb.pop_front();
                $display("valid at cycle %0d: period=%0d high_time=%0d (required %0d/%0d @%0d)",
                         cyc, period, high_time, e.p, e.h, e.at);
                if (period !== e.p || high_time !== e.h || cyc != e.at) begin
                    miscompares++;
                    $display("FAIL result: period=%0d high_time=%0d cycle=%0d, required period=%0d high_time=%0d cycle=%0d",
                             period, high_time, cyc, e.p, e.h, e.at);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        sig_in = 1'b0;
        tick(3);
        vectors++;
        if (period !== 0 || high_time !== 0 || valid !== 1'b0 || no_signal !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: period=%0d high=%0d valid=%b no_signal=%b, required 0 0 0 1",
                     period, high_time, valid, no_signal);
        end
        rst_n = 1'b1;
        tick(50);
        vectors++;
        if (period !== 0 || valid !== 1'b0 || no_signal !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_after_50: period=%0d valid=%b no_signal=%b, required 0 0 1",
                     period, valid, no_signal);
        end
    endtask

    task automatic test_square();
        for (int i = 0; i < 5; i++) run_cycle(10, 4);
        vectors++;
        if (no_signal !== 1'b0) begin
            miscompares++;
            $display("FAIL square_no_signal: got %b, required 0", no_signal);
        end
    endtask

    task automatic test_change();
        for (int i = 0; i < 3; i++) run_cycle(37, 20);
    endtask

    task automatic test_min_phase();
        for (int i = 0; i < 4; i++) run_cycle(2, 1);
    endtask

    task automatic test_timeout();
        int r;
        int exp_h;
`ifdef FREQ_METER_DUTY_EN
        exp_h = 1;
`else
        exp_h = 0;
`endif
        do_rise();
        r = cyc;
        tick(4);
        do_fall();
        while (cyc < r + 1003) tick(1);
        vectors++;
        if (no_signal !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: no_signal=%b at cycle %0d, required 0", no_signal, cyc);
        end
        tick(1);
        vectors++;
        if (no_signal !== 1'b1 || period !== 2 || high_time !== exp_h) begin
            miscompares++;
            $display("FAIL timeout_hold: no_signal=%b period=%0d high=%0d, required 1 2 %0d",
                     no_signal, period, high_time, exp_h);
        end
        armed = 1'b0;
        tick(20);
        for (int i = 0; i < 2; i++) run_cycle(10, 4);
        vectors++;
        if (no_signal !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_no_signal: got %b, required 0", no_signal);
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 2; i++) run_cycle(1000, 500);
        do_rise();
        tick(6);
        vectors++;
        if (no_signal !== 1'b0 || period !== 1000) begin
            miscompares++;
            $display("FAIL boundary: no_signal=%b period=%0d, required 0 1000", no_signal, period);
        end
    endtask

    task automatic test_async_reset();
        tick(20);
        do_fall();
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (period !== 0 || high_time !== 0 || valid !== 1'b0 || no_signal !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: period=%0d high=%0d valid=%b no_signal=%b, required 0 0 0 1",
                     period, high_time, valid, no_signal);
        end
        tick(1);
        rst_n = 1'b1;
        armed = 1'b0;
        fell = 1'b0;
        tick(5);
        for (int i = 0; i < 2; i++) run_cycle(12, 5);
        do_rise();
        tick(8);
        vectors++;
        if (period !== 12 || no_signal !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: period=%0d no_signal=%b, required 12 0", period, no_signal);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_square();
        test_change();
        test_min_phase();
        test_timeout();
        test_boundary();
        test_async_reset();
        tick(10);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_valid: %0d results outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
